// File: rtl/enc_bundler_acc_pkg.sv
// Shared enc package: hypervector geometry, bundler state
// encoding and derived counter width.
package enc_bundler_acc_pkg;

  localparam int HV_DIM          = 16;
  localparam int FEATURES_PER_CC = 4;
  localparam int NUM_FEATURES    = 616;
  localparam int CNT_W = $clog2(NUM_FEATURES + 1);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } bundler_state_t;

endpackage

// File: rtl/enc_bundler_acc_if.sv
// Beat input stream and sample output stream of the
// bundler; master drives beats, slave is the bundler.
interface enc_bundler_acc_if;
  import enc_bundler_acc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [HV_DIM-1:0] shifted_hv [0:FEATURES_PER_CC-1];
  logic              out_valid;
  logic              out_ready;
  logic [HV_DIM-1:0] out_hv;

  modport master (
    output in_valid,
    output shifted_hv,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_hv
  );

  modport slave (
    input  in_valid,
    input  shifted_hv,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_hv
  );

endinterface

// File: rtl/enc_bundler_col.sv
// One hypervector bit column: popcount of the beat's bits,
// running count, and registered threshold decision.
module enc_bundler_col
  import enc_bundler_acc_pkg::*;
#(
  parameter int FPC       = FEATURES_PER_CC,
  parameter int CW        = CNT_W,
  parameter int THRESHOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [FPC-1:0] bits,
  input  logic           add_en,
  input  logic           clear,
  input  logic           capture,
  output logic           hv_bit
);

  localparam logic [CW-1:0] THR = CW'(THRESHOLD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] pop;
  logic [CW-1:0] sum;

  // count of set bits among this beat's vectors
  always_comb begin
    pop = '0;
    for (int i = 0; i < FPC; i++) begin
      pop = pop + CW'(bits[i]);
    end
  end

  assign sum = cnt + pop;

  // running per-bit sum; clear wins over accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (add_en) begin
      cnt <= sum;
    end
  end

  // threshold on the updated sum at the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hv_bit <= 1'b0;
    end else if (capture) begin
      hv_bit <= (sum >= THR);
    end
  end

endmodule

// File: rtl/enc_bundler_acc.sv
// Bundler: accumulates NUM_FEATURES bound hypervectors per
// sample and emits the thresholded sample hypervector.
// Optional abort port clr enabled by ENC_BUNDLER_CLR_EN.
module enc_bundler_acc
  import enc_bundler_acc_pkg::*;
#(
  parameter int NUM_FEATURES =
    enc_bundler_acc_pkg::NUM_FEATURES,
  parameter int THRESHOLD = 8
) (
  input logic               clk,
  input logic               rst,
  enc_bundler_acc_if.slave  bus
`ifdef ENC_BUNDLER_CLR_EN
  ,
  input logic               clr
`endif
);

  localparam int NUM_CHUNKS =
    NUM_FEATURES / FEATURES_PER_CC;
  localparam int CW = $clog2(NUM_FEATURES + 1);
  localparam int CHK_W =
    (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CHK_W-1:0] LAST =
    CHK_W'(NUM_CHUNKS - 1);

  bundler_state_t   state;
  bundler_state_t   nxt;
  logic [CHK_W-1:0] chunk_cnt;
  logic             clr_i;
  logic             accept;
  logic             last;
  logic             add_en;
  logic             clear;
  logic             capture;
  logic [HV_DIM-1:0] hv_q;

`ifdef ENC_BUNDLER_CLR_EN
  assign clr_i = clr;
`else
  assign clr_i = 1'b0;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (chunk_cnt == LAST);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= nxt;
    end
  end

  // next state: abort first, then beat / handshake
  always_comb begin
    nxt = state;
    if (clr_i) begin
      nxt = ACC;
    end else begin
      unique case (state)
        ACC: if (accept && last) nxt = OUT;
        OUT: if (bus.out_ready)  nxt = ACC;
        default: nxt = ACC;
      endcase
    end
  end

  // handshake outputs and column controls
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    add_en        = 1'b0;
    capture       = 1'b0;
    clear         = clr_i;
    unique case (state)
      ACC: begin
        bus.in_ready = !clr_i;
        add_en       = accept;
        capture      = accept && last;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        clear         = clr_i || bus.out_ready;
      end
      default: ;
    endcase
  end

  // beat index within the current sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chunk_cnt <= '0;
    end else if (clr_i) begin
      chunk_cnt <= '0;
    end else if (accept) begin
      chunk_cnt <= last ? '0 : chunk_cnt + 1'b1;
    end
  end

  for (genvar b = 0; b < HV_DIM; b++) begin : g_col
    logic [FEATURES_PER_CC-1:0] col_bits;

    // gather bit b of every vector in the beat
    always_comb begin
      col_bits = '0;
      for (int f = 0; f < FEATURES_PER_CC; f++) begin
        col_bits[f] = bus.shifted_hv[f][b];
      end
    end

    enc_bundler_col #(
      .FPC       (FEATURES_PER_CC),
      .CW        (CW),
      .THRESHOLD (THRESHOLD)
    ) u_col (
      .clk     (clk),
      .rst     (rst),
      .bits    (col_bits),
      .add_en  (add_en),
      .clear   (clear),
      .capture (capture),
      .hv_bit  (hv_q[b])
    );
  end

  assign bus.out_hv = hv_q;

endmodule

// File: tb/tb_enc_bundler_acc.sv
// Bench for enc_bundler_acc: vector table, corner sequences
// and randomized samples against a per-bit counting model.
module tb_enc_bundler_acc;
  import enc_bundler_acc_pkg::*;

  localparam int NF  = 8;
  localparam int TH  = 3;
  localparam int FPC = FEATURES_PER_CC;
  localparam int NCH = NF / FPC;

  typedef logic [FPC-1:0][HV_DIM-1:0] beat_t;
  typedef logic [NCH-1:0][FPC-1:0][HV_DIM-1:0] samp_t;

  typedef struct {
    samp_t             v;
    logic [HV_DIM-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
`ifdef ENC_BUNDLER_CLR_EN
  logic clr = 1'b0;
`endif

  always #5 clk = ~clk;

  enc_bundler_acc_if bus ();

  enc_bundler_acc #(
    .NUM_FEATURES (NF),
    .THRESHOLD    (TH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ENC_BUNDLER_CLR_EN
    ,
    .clr (clr)
`endif
  );

  int checks   = 0;
  int failures = 0;
  vec_t tbl [0:5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  function automatic logic [HV_DIM-1:0] model(
      input samp_t s);
    logic [HV_DIM-1:0] r;
    int c;
    r = '0;
    for (int b = 0; b < HV_DIM; b++) begin
      c = 0;
      for (int k = 0; k < NCH; k++)
        for (int f = 0; f < FPC; f++)
          c += int'(s[k][f][b]);
      r[b] = (c >= TH);
    end
    return r;
  endfunction

  task automatic set_hv(input beat_t v);
    for (int f = 0; f < FPC; f++)
      bus.shifted_hv[f] = v[f];
  endtask

  task automatic send_beat(input beat_t v,
                           input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    set_hv(v);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic get_out(input logic [HV_DIM-1:0] exp,
                         input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(bus.out_valid), 1);
    check({name, "_lat"}, n, 0);
    check(name, 32'(bus.out_hv), 32'(exp));
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
      check({name, "_drop"}, 32'(bus.out_valid), 0);
    end
  endtask

  task automatic set_vec(input int i,
      input logic [15:0] a0, a1, a2, a3,
      input logic [15:0] b0, b1, b2, b3,
      input logic [15:0] e);
    tbl[i].v[0][0] = a0; tbl[i].v[0][1] = a1;
    tbl[i].v[0][2] = a2; tbl[i].v[0][3] = a3;
    tbl[i].v[1][0] = b0; tbl[i].v[1][1] = b1;
    tbl[i].v[1][2] = b2; tbl[i].v[1][3] = b3;
    tbl[i].exp = e;
  endtask

  initial begin
    beat_t z;
    beat_t bf;
    beat_t b1;
    samp_t rs;
    logic [HV_DIM-1:0] e;
    logic [HV_DIM-1:0] m;
    int hold;

    z  = '0;
    bf = '1;

    set_vec(0, 16'h000F, 16'h000F, 16'h000F, 16'h000F,
               16'h000F, 16'h000F, 16'h000F, 16'h000F,
               16'h000F);
    set_vec(1, 16'h0001, 16'h0001, 16'h0001, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0001);
    set_vec(2, 16'h0001, 16'h0001, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0000);
    set_vec(3, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
               16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
               16'hFFFF);
    set_vec(4, 16'hF0F0, 16'h0F0F, 16'hFF00, 16'h00FF,
               16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0000);
    set_vec(5, 16'h8003, 16'h8001, 16'h8000, 16'h0000,
               16'h8002, 16'h0000, 16'h0000, 16'h0000,
               16'h8000);

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_hv(z);

    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_hv", 32'(bus.out_hv), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid2", 32'(bus.out_valid), 0);

    // table: back-to-back, then 3-cycle gaps
    for (int g = 0; g <= 3; g += 3) begin
      for (int i = 0; i < 6; i++) begin
        send_beat(tbl[i].v[0], 0);
        send_beat(tbl[i].v[1], g);
        get_out(tbl[i].exp,
                $sformatf("vec%0d_gap%0d", i, g));
      end
    end

    // backpressure with a third beat waiting
    bus.out_ready = 1'b0;
    send_beat(tbl[0].v[0], 0);
    send_beat(tbl[0].v[1], 0);
    b1 = '0;
    b1[0] = 16'h0010;
    b1[1] = 16'h0010;
    bus.in_valid = 1'b1;
    set_hv(b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 1);
      check("bp_hv", 32'(bus.out_hv), 32'h000F);
      check("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_mid_sample", 32'(bus.out_valid), 0);
    send_beat(z, 0);
    get_out(16'h0000, "bp_next");

    // reset mid-sample discards partial sums
    b1 = '0;
    b1[0] = 16'h0001;
    send_beat(b1, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    b1[1] = 16'h0001;
    send_beat(b1, 0);
    check("rst_chunk", 32'(bus.out_valid), 0);
    send_beat(z, 0);
    get_out(16'h0000, "rst_carry");
    send_beat(bf, 0);
    send_beat(bf, 0);
    get_out(16'hFFFF, "rst_ffff");

`ifdef ENC_BUNDLER_CLR_EN
    // abort together with the last beat
    send_beat(tbl[0].v[0], 0);
    @(negedge clk);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    set_hv(bf);
    #1;
    check("clr_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_beat_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    check("clr_beat_valid2", 32'(bus.out_valid), 0);
    send_beat(tbl[1].v[0], 0);
    send_beat(tbl[1].v[1], 0);
    get_out(tbl[1].exp, "clr_after");
    // abort while the output is pending
    bus.out_ready = 1'b0;
    send_beat(tbl[0].v[0], 0);
    send_beat(tbl[0].v[1], 0);
    @(negedge clk);
    check("clr_out_pre", 32'(bus.out_valid), 1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_out_drop", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
`endif

    // randomized samples against the counting model
    for (int s = 0; s < 30; s++) begin
      for (int k = 0; k < NCH; k++)
        for (int f = 0; f < FPC; f++) begin
          m = HV_DIM'($urandom);
          rs[k][f] = HV_DIM'($urandom) & m;
        end
      e = model(rs);
      hold = $urandom_range(0, 1) ? 0
           : int'($urandom_range(1, 4));
      bus.out_ready = (hold == 0);
      for (int k = 0; k < NCH; k++)
        send_beat(rs[k], int'($urandom_range(0, 2)));
      get_out(e, $sformatf("rand%0d", s));
      if (hold != 0) begin
        repeat (hold) @(negedge clk);
        check("rand_hold_hv", 32'(bus.out_hv), 32'(e));
        check("rand_hold_rdy", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rand_hold_drop",
              32'(bus.out_valid), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/enc_bundler_acc.md
# enc_bundler_acc

- Downstream of the encoder binder packs.
- Each accepted beat carries FEATURES_PER_CC shifted hypervectors from one binder pack.
- Per hypervector bit position, the block sums the set bits across all NUM_FEATURES features of a sample, spread over NUM_FEATURES/FEATURES_PER_CC beats.
- When the last beat is in, it thresholds the per-bit counts into one sparse sample hypervector and hands it to the classifier/similarity stage over a valid/ready handshake.

## Interface
- HV_DIM, from enc package: hypervector width in bits
- FEATURES_PER_CC, from enc package: hypervectors per input beat
- NUM_FEATURES, 616: features per sample; must be a multiple of FEATURES_PER_CC
- THRESHOLD, 8: output bit is 1 when its count >= THRESHOLD; legal range 1..NUM_FEATURES
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept a beat
- shifted_hv  in  HV_DIM x [0:FEATURES_PER_CC-1]  bound feature hypervectors
- out_valid  out  1  sample hypervector valid
- out_ready  in  1  consumer accepts
- out_hv  out  HV_DIM  thresholded sample hypervector
- clr  in  1  synchronous abort; present only with ENC_BUNDLER_CLR_EN

## Operation
- NUM_CHUNKS = NUM_FEATURES/FEATURES_PER_CC.
- CNT_W = $clog2(NUM_FEATURES+1). Per-bit counters never overflow; no saturation logic.
- CHK_W = $clog2(NUM_CHUNKS), minimum 1.
- Two states, ACC and OUT.
- ACC state:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, each bit counter adds the popcount of that bit across the FEATURES_PER_CC input vectors.
  - chunk_cnt increments on each accepted beat.
  - On the beat with chunk_cnt==NUM_CHUNKS-1:
    - out_hv[b] <= (cnt[b] + pop[b] >= THRESHOLD), computed on the updated sum.
    - chunk_cnt <= 0.
    - State -> OUT.
- OUT state:
  - in_ready=0; out_valid=1; out_hv held stable.
  - On out_ready, state -> ACC and all counters clear on the same edge.
  - out_ready ignored while out_valid=0.
- A beat with in_valid=0 leaves counters and chunk_cnt unchanged. Gaps between beats are allowed.
- NUM_CHUNKS==1: every accepted beat goes directly to OUT.

## Timing
- Reset values: state=ACC, counters=0, chunk_cnt=0, out_valid=0, out_hv=0, in_ready=1 after reset deassertion.
- rst asserted mid-sample or during OUT: partial sums are discarded immediately, with no output.
- Latency: out_valid rises on the edge that accepts the last beat, so it is visible the cycle after that beat.
- Throughput: at most one sample per NUM_CHUNKS+1 cycles; the output handshake cycle accepts no input beat.
- out_hv is registered; no combinational path from shifted_hv to out_hv.
- out_ready high continuously: OUT lasts exactly one cycle.

## Configuration
- ENC_BUNDLER_CLR_EN defined:
  - clr port exists.
  - clr=1 at any edge forces state=ACC, counters=0, chunk_cnt=0, out_valid=0, and drops any pending output.
  - clr has priority over a simultaneous input beat or output handshake.
  - in_ready is 0 during the clr cycle.
- Undefined: no clr port; behaviour is as above without abort.

## Structure
- Shared enc package holds:
  - HV_DIM, FEATURES_PER_CC, NUM_FEATURES
  - the bundler state enum typedef (ACC, OUT)
  - CNT_W as a derived localparam
- Sub-module enc_bundler_col: one bit column, generated HV_DIM times.
  - Inputs: FEATURES_PER_CC input bits.
  - Contents: popcount, CNT_W counter, threshold compare.
  - Control: add_en, clear, capture from the parent FSM.
- The parent owns the FSM, chunk_cnt and handshakes.

## Test plan
Bench parameters: HV_DIM=16, FEATURES_PER_CC=4, NUM_FEATURES=8, THRESHOLD=3.
- Two beats, all vectors 16'h000F -> bits 0-3 count 8 -> out_hv=16'h000F; out_valid exactly one cycle after beat 2.
- Beat 1 has three vectors 16'h0001, beat 2 all zero -> count=3 -> out_hv=16'h0001. Same with two vectors 16'h0001 -> count=2 -> out_hv=16'h0000.
- Backpressure: out_ready=0 for 5 cycles -> out_hv stable, in_ready=0 throughout; a third beat offered is not taken. Release -> the next sample's sums start from 0.
- in_valid gaps of 3 cycles between beats -> same result as back-to-back beats.
- rst pulsed after beat 1 -> no output; the next two beats of 16'hFFFF -> out_hv=16'hFFFF with no carry-over.
- With ENC_BUNDLER_CLR_EN: clr together with beat 2 -> no out_valid. clr during OUT -> out_valid drops the next cycle.
